// File: rtl/signal_phase_arbiter.sv
// Demand-actuated phase arbiter for the four-approach intersection (RS, RD, RT, LD).
// Round-robin green grants with min/max green, fixed yellow, all-red clearance and emergency preempt.
module signal_phase_arbiter #(
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALL_RED   = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [2:0] light_RS,
  output logic [2:0] light_RD,
  output logic [2:0] light_RT,
  output logic [2:0] light_LD,
  output logic [1:0] active_dir,
  output logic       green_valid,
  output logic       preempt_ack,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GREEN   = 2'd1;
  localparam logic [1:0] S_YELLOW  = 2'd2;
  localparam logic [1:0] S_ALL_RED = 2'd3;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       last_q, last_d;
  logic             pre_q, pre_d;

  logic       grant_ok;
  logic [1:0] grant_sel;
  logic       grant_pre;
  logic [1:0] idx;
  logic [3:0] active_mask;
  logic       pre_hold;
  logic       pre_other;
  logic       green_exit;

  // Preempt wins; otherwise scan last+1, last+2, last+3, last.
  always_comb begin
    grant_ok  = 1'b0;
    grant_sel = 2'd0;
    grant_pre = 1'b0;
    idx       = 2'd0;
    if (preempt) begin
      grant_ok  = 1'b1;
      grant_sel = preempt_dir;
      grant_pre = 1'b1;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        idx = last_q + i[1:0];
        if (!grant_ok && req[idx]) begin
          grant_ok  = 1'b1;
          grant_sel = idx;
        end
      end
    end
  end

  always_comb begin
    active_mask = 4'b0001 << dir_q;
    pre_hold    = preempt && (preempt_dir == dir_q);
    pre_other   = preempt && (preempt_dir != dir_q);
    green_exit  = pre_other
               || (!pre_hold && (count_q >= CNT_W'(T_MAX_GREEN - 1)))
               || (!pre_hold && (count_q >= CNT_W'(T_MIN_GREEN - 1))
                   && (!req[dir_q] || ((req & ~active_mask) != 4'b0000)));
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    pre_d   = pre_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          state_d = S_GREEN;
          dir_d   = grant_sel;
          last_d  = grant_sel;
          pre_d   = grant_pre;
        end
      end
      S_GREEN: begin
        if (green_exit) state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (count_q == CNT_W'(T_YELLOW - 1)) state_d = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (count_q == CNT_W'(T_ALL_RED - 1)) begin
          if (grant_ok) begin
            state_d = S_GREEN;
            dir_d   = grant_sel;
            last_d  = grant_sel;
            pre_d   = grant_pre;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates so a long preempt hold cannot wrap it.
  always_comb begin
    if (state_d != state_q) count_d = '0;
    else if (&count_q)      count_d = count_q;
    else                    count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dir_q   <= 2'd0;
      last_q  <= 2'd3;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      pre_q   <= pre_d;
    end
  end

  logic [11:0] heads;

  always_comb begin
    heads = {L_RED, L_RED, L_RED, L_RED};
    case (state_q)
      S_GREEN:  heads[dir_q*3 +: 3] = L_GREEN;
      S_YELLOW: heads[dir_q*3 +: 3] = L_YELLOW;
      default:  heads = {L_RED, L_RED, L_RED, L_RED};
    endcase
  end

  assign light_RS    = heads[2:0];
  assign light_RD    = heads[5:3];
  assign light_RT    = heads[8:6];
  assign light_LD    = heads[11:9];
  assign active_dir  = dir_q;
  assign green_valid = (state_q == S_GREEN);
  assign preempt_ack = (state_q == S_GREEN) && pre_q && preempt;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_signal_phase_arbiter.sv
// Directed bench for signal_phase_arbiter: cycle-by-cycle phase sequences with hand-derived expectations.
// Inputs are driven and outputs sampled on the falling edge.
module tb_signal_phase_arbiter;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_GREEN = 2'd1;
  localparam logic [1:0] P_YEL   = 2'd2;
  localparam logic [1:0] P_RED   = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [2:0] light_RS, light_RD, light_RT, light_LD;
  logic [1:0] active_dir;
  logic       green_valid;
  logic       preempt_ack;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  signal_phase_arbiter #(
    .T_MIN_GREEN(4), .T_MAX_GREEN(8), .T_YELLOW(2), .T_ALL_RED(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .preempt(preempt), .preempt_dir(preempt_dir),
    .light_RS(light_RS), .light_RD(light_RD), .light_RT(light_RT), .light_LD(light_LD),
    .active_dir(active_dir), .green_valid(green_valid), .preempt_ack(preempt_ack),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Heads packed {LD, RT, RD, RS}; red everywhere except the active head in GREEN/YELLOW.
  function automatic logic [11:0] heads_for(input logic [1:0] ph, input logic [1:0] dir);
    logic [11:0] v;
    v = 12'b100_100_100_100;
    if (ph == P_GREEN) v[dir*3 +: 3] = 3'b001;
    if (ph == P_YEL)   v[dir*3 +: 3] = 3'b010;
    return v;
  endfunction

  task automatic expect_run(input string tag, input int n, input logic [1:0] ph,
                            input logic [1:0] dir, input logic ack);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, ".lights"}, {20'd0, light_LD, light_RT, light_RD, light_RS}, {20'd0, heads_for(ph, dir)});
      check({tag, ".dir"},    {30'd0, active_dir}, {30'd0, dir});
      check({tag, ".gv"},     {31'd0, green_valid}, {31'd0, (ph == P_GREEN)});
      check({tag, ".ack"},    {31'd0, preempt_ack}, {31'd0, ack});
      check({tag, ".state"},  {30'd0, dbg_state}, {30'd0, ph});
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; preempt = 1'b0; preempt_dir = 2'd0;
    repeat (2) @(negedge clk);
    check("rst.lights", {20'd0, light_LD, light_RT, light_RD, light_RS}, 32'h924);
    check("rst.gv",     {31'd0, green_valid}, 32'd0);
    check("rst.ack",    {31'd0, preempt_ack}, 32'd0);
    check("rst.dir",    {30'd0, active_dir}, 32'd0);
    rst = 1'b0;
    expect_run("idle0", 2, P_IDLE, 2'd0, 1'b0);

    // Two requesters alternate at minimum green (last=3 after reset, so RS first).
    req = 4'b0011;
    expect_run("alt.g0", 4, P_GREEN, 2'd0, 1'b0);
    expect_run("alt.y0", 2, P_YEL,   2'd0, 1'b0);
    expect_run("alt.r0", 1, P_RED,   2'd0, 1'b0);
    expect_run("alt.g1", 4, P_GREEN, 2'd1, 1'b0);
    expect_run("alt.y1", 2, P_YEL,   2'd1, 1'b0);
    expect_run("alt.r1", 1, P_RED,   2'd1, 1'b0);
    expect_run("alt.g0b", 1, P_GREEN, 2'd0, 1'b0);
    req = 4'b0000;
    expect_run("alt.g0c", 3, P_GREEN, 2'd0, 1'b0);
    expect_run("alt.y0c", 2, P_YEL,   2'd0, 1'b0);
    expect_run("alt.r0c", 1, P_RED,   2'd0, 1'b0);
    expect_run("alt.idle", 1, P_IDLE, 2'd0, 1'b0);

    // Sole requester runs to max green, then is re-granted.
    req = 4'b0001;
    expect_run("max.g0", 8, P_GREEN, 2'd0, 1'b0);
    expect_run("max.y0", 2, P_YEL,   2'd0, 1'b0);
    expect_run("max.r0", 1, P_RED,   2'd0, 1'b0);
    expect_run("max.g0b", 1, P_GREEN, 2'd0, 1'b0);
    req = 4'b0000;
    expect_run("max.g0c", 3, P_GREEN, 2'd0, 1'b0);
    expect_run("max.y0c", 2, P_YEL,   2'd0, 1'b0);
    expect_run("max.r0c", 1, P_RED,   2'd0, 1'b0);
    expect_run("max.idle", 1, P_IDLE, 2'd0, 1'b0);

    // One-cycle RT pulse still gets the full minimum green.
    req = 4'b0100;
    expect_run("pulse.g2", 1, P_GREEN, 2'd2, 1'b0);
    req = 4'b0000;
    expect_run("pulse.g2b", 3, P_GREEN, 2'd2, 1'b0);
    expect_run("pulse.y2",  2, P_YEL,   2'd2, 1'b0);
    expect_run("pulse.r2",  1, P_RED,   2'd2, 1'b0);
    expect_run("pulse.idle", 2, P_IDLE, 2'd2, 1'b0);

    // Preempt to LD while RS green at count 1: immediate yellow, then held preempt green.
    req = 4'b0001;
    expect_run("pre.g0", 2, P_GREEN, 2'd0, 1'b0);
    preempt = 1'b1; preempt_dir = 2'd3;
    expect_run("pre.y0", 2, P_YEL,   2'd0, 1'b0);
    expect_run("pre.r0", 1, P_RED,   2'd0, 1'b0);
    expect_run("pre.g3", 20, P_GREEN, 2'd3, 1'b1);
    preempt = 1'b0; req = 4'b0000;
    #1;
    check("pre.ack_drop", {31'd0, preempt_ack}, 32'd0);
    check("pre.gv_drop",  {31'd0, green_valid}, 32'd1);
    expect_run("pre.y3", 2, P_YEL,   2'd3, 1'b0);
    expect_run("pre.r3", 1, P_RED,   2'd3, 1'b0);
    expect_run("pre.idle", 1, P_IDLE, 2'd3, 1'b0);

    // Wrap-around: last=3 with req=1001 grants RS first, then LD.
    req = 4'b1001;
    expect_run("wrap.g0", 4, P_GREEN, 2'd0, 1'b0);
    expect_run("wrap.y0", 2, P_YEL,   2'd0, 1'b0);
    expect_run("wrap.r0", 1, P_RED,   2'd0, 1'b0);
    expect_run("wrap.g3", 1, P_GREEN, 2'd3, 1'b0);
    req = 4'b0000;
    expect_run("wrap.g3b", 3, P_GREEN, 2'd3, 1'b0);
    expect_run("wrap.y3",  2, P_YEL,   2'd3, 1'b0);
    expect_run("wrap.r3",  1, P_RED,   2'd3, 1'b0);
    expect_run("wrap.idle", 1, P_IDLE, 2'd3, 1'b0);

    // Asynchronous reset mid-GREEN (RS green, count 2).
    req = 4'b0001;
    expect_run("mid.g0", 3, P_GREEN, 2'd0, 1'b0);
    req = 4'b0000; rst = 1'b1;
    #1;
    check("mid.lights", {20'd0, light_LD, light_RT, light_RD, light_RS}, 32'h924);
    check("mid.gv",     {31'd0, green_valid}, 32'd0);
    check("mid.state",  {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_run("mid.idle", 1, P_IDLE, 2'd0, 1'b0);

    // Preempt beats a simultaneous request in IDLE.
    req = 4'b0001; preempt = 1'b1; preempt_dir = 2'd2;
    expect_run("race.g2", 2, P_GREEN, 2'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
